io_dispatch_hub: RTL and testbench
==================================

// Module: io_dispatch_hub
// PURPOSE
//   Parametrised processor-to-peripheral dispatch and interrupt hub.
//   Routes processor write strobes to NUM_OUT output channels (PPU, accelerator, comm, ...).
//   Each channel has a registered holding slot and a valid/ready handshake.
//   Collects NUM_IRQ edge-triggered interrupt sources (keyboard, network, ...) into a single
//   arbitrated request with ID and captured data, held until acknowledged.
// PARAMETERS
//   DATA_W   32  width of processor data and interrupt payload
//   NUM_OUT  3   number of output channels (>=1)
//   NUM_IRQ  2   number of interrupt sources (>=1)
//   SEL_W    $clog2(NUM_OUT) (min 1)  channel select width, derived
//   ID_W     $clog2(NUM_IRQ) (min 1)  interrupt ID width, derived
// PORTS
//   sys_clk       in   1               system clock, all logic on posedge
//   rst           in   1               synchronous reset, active-high
//   cpu_wr        in   1               processor write strobe, one cycle per write
//   cpu_sel       in   SEL_W           target channel for cpu_wr
//   cpu_data      in   DATA_W          write payload
//   cpu_busy      out  1               comb: out_valid[cpu_sel] & ~out_ready[cpu_sel]
//   out_valid     out  NUM_OUT         per-channel holding slot full
//   out_data      out  NUM_OUT*DATA_W  per-channel payload; channel i at [i*DATA_W +: DATA_W]
//   out_ready     in   NUM_OUT         per-channel consumer ready
//   irq_src       in   NUM_IRQ         interrupt source lines; rising edge = event
//   irq_src_data  in   NUM_IRQ*DATA_W  source payloads, sampled on the edge cycle
//   irq_req       out  1               interrupt request to processor
//   irq_id        out  ID_W            index of the granted source
//   irq_data      out  DATA_W          payload of the granted source
//   irq_ack       in   1               processor acknowledge
//   irq_overflow  out  NUM_IRQ         sticky: event arrived while that source was already pending
// BEHAVIOUR
//   Reset: out_valid, out_data, irq_req, irq_id, irq_data, irq_overflow, pending, edge regs all 0.
//   Output channel i:
//     - Accept when cpu_wr & cpu_sel==i & (~out_valid[i] | out_ready[i]).
//     - On accept: out_data[i] <= cpu_data; out_valid[i] <= 1 (1-cycle latency).
//     - When out_valid[i] & out_ready[i] and no accept that cycle: out_valid[i] <= 0.
//     - Full + ready + write in the same cycle: drain and refill; valid stays 1; new data shown next cycle.
//     - Write while busy is dropped; the slot and its data are unchanged.
//     - cpu_sel >= NUM_OUT: write ignored; cpu_busy=0.
//   Interrupt capture, per source j:
//     - prev[j] <= irq_src[j]; edge[j] = irq_src[j] & ~prev[j].
//     - Edge & ~pending[j]: pending[j] <= 1; data[j] <= irq_src_data[j].
//     - Edge & pending[j]: irq_overflow[j] <= 1; first captured data is kept.
//     - Edge in the same cycle as the ack that clears j: set wins; pending stays 1 with the new data.
//   Arbiter FSM:
//     - IDLE: if any pending, select winner (lowest index by default).
//       Load irq_id and irq_data; next cycle irq_req=1 -> REQ.
//     - REQ: irq_req, irq_id and irq_data are held stable. On irq_ack: clear pending[irq_id];
//       irq_req <= 0; -> IDLE.
//     - Earliest next grant is 2 cycles after the ack cycle.
//     - irq_ack in IDLE is ignored. A new higher-priority event during REQ does not preempt.
//   irq_overflow is cleared only by rst. Reset mid-handshake returns to IDLE with everything cleared.
// CONFIGURATION
//   IRQ_ROUND_ROBIN_EN defined:
//     - Round-robin arbitration: a last-grant pointer (reset 0) is updated on each ack.
//     - Search starts at last+1 and wraps modulo NUM_IRQ.
//   Not defined: fixed priority, lowest index wins. Ports and timing are identical either way.
// TESTING
//   1 Write ch1=0xDEAD_BEEF with out_ready=0 -> out_valid=3'b010 next cycle; 2nd write ch1 dropped,
//     cpu_busy=1; ready=1 one cycle -> valid clears.
//   2 ch0 full, out_ready[0]=1 and write 0x55 same cycle -> out_valid[0] stays 1, out_data[0]=0x55.
//   3 Edge on src0 (data 103) -> irq_req=1 two cycles later, irq_id=0, irq_data=103; ack -> irq_req=0.
//   4 Edges on src0 and src1 same cycle -> grant id 0, ack, grant id 1 two cycles later (fixed priority).
//     With IRQ_ROUND_ROBIN_EN and last=0: id 1 first.
//   5 Two edges on src1 before ack -> irq_overflow=2'b10, irq_data = first payload; overflow survives ack.
//   6 rst asserted while irq_req=1 and out_valid=3'b111 -> all outputs 0 next cycle; a late ack is ignored.

Source files
------------

// File: rtl/io_dispatch_hub_if.sv
// rtl/io_dispatch_hub_if.sv - processor write, output channel and interrupt signal bundle
interface io_dispatch_hub_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_OUT = 3,
  parameter int NUM_IRQ = 2
);
  localparam int SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int ID_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic                      cpu_wr;
  logic [SEL_W-1:0]          cpu_sel;
  logic [DATA_W-1:0]         cpu_data;
  logic                      cpu_busy;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_ready;
  logic [NUM_IRQ-1:0]        irq_src;
  logic [NUM_IRQ*DATA_W-1:0] irq_src_data;
  logic                      irq_req;
  logic [ID_W-1:0]           irq_id;
  logic [DATA_W-1:0]         irq_data;
  logic                      irq_ack;
  logic [NUM_IRQ-1:0]        irq_overflow;

  modport master (
    output cpu_wr, cpu_sel, cpu_data, out_ready, irq_src, irq_src_data, irq_ack,
    input  cpu_busy, out_valid, out_data, irq_req, irq_id, irq_data, irq_overflow
  );

  modport slave (
    input  cpu_wr, cpu_sel, cpu_data, out_ready, irq_src, irq_src_data, irq_ack,
    output cpu_busy, out_valid, out_data, irq_req, irq_id, irq_data, irq_overflow
  );
endinterface

// File: rtl/io_dispatch_hub.sv
// rtl/io_dispatch_hub.sv - processor-to-peripheral dispatch slots plus edge-triggered interrupt arbiter
// Optional round-robin interrupt arbitration is enabled by defining IRQ_ROUND_ROBIN_EN.
module io_dispatch_hub #(
  parameter int DATA_W  = 32,
  parameter int NUM_OUT = 3,
  parameter int NUM_IRQ = 2
) (
  input logic              sys_clk,
  input logic              rst,
  io_dispatch_hub_if.slave bus
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_OUT-1:0]        out_valid_q, out_valid_d;
  logic [NUM_OUT*DATA_W-1:0] out_data_q, out_data_d;
  logic                      busy_w;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_w      = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (int'(bus.cpu_sel) == i) begin
        busy_w = out_valid_q[i] & ~bus.out_ready[i];
      end
      // A write into a slot that drains this cycle refills it, so valid never drops.
      if (bus.cpu_wr && int'(bus.cpu_sel) == i && (!out_valid_q[i] || bus.out_ready[i])) begin
        out_valid_d[i]                  = 1'b1;
        out_data_d[i*DATA_W +: DATA_W] = bus.cpu_data;
      end else if (bus.out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.cpu_busy  = busy_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  typedef enum logic {ST_IDLE, ST_REQ} state_e;

  state_e             state_q;
  logic [NUM_IRQ-1:0] prev_q, pending_q, ovf_q;
  logic [DATA_W-1:0]  cap_q [NUM_IRQ];
  logic               req_q;
  logic [ID_W-1:0]    id_q;
  logic [DATA_W-1:0]  data_q;
`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]    last_q;
`endif

  logic [NUM_IRQ-1:0] edge_w, clr_w, rot_w;
  logic               found_w;
  logic [ID_W-1:0]    winner_w;
  int                 start_w, idx_w;

  always_comb begin
    edge_w = bus.irq_src & ~prev_q;
    clr_w  = '0;
    if (state_q == ST_REQ && bus.irq_ack) begin
      clr_w[id_q] = 1'b1;
    end
  end

  always_comb begin
    found_w  = 1'b0;
    winner_w = '0;
    rot_w    = '0;
    idx_w    = 0;
`ifdef IRQ_ROUND_ROBIN_EN
    start_w  = int'(last_q) + 1;
`else
    start_w  = 0;
`endif
    for (int k = 0; k < NUM_IRQ; k++) begin
      idx_w = (start_w + k) % NUM_IRQ;
      rot_w = pending_q >> idx_w;
      if (!found_w && rot_w[0]) begin
        found_w  = 1'b1;
        winner_w = ID_W'(idx_w);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      id_q      <= '0;
      data_q    <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
      last_q    <= '0;
`endif
      for (int j = 0; j < NUM_IRQ; j++) begin
        cap_q[j] <= '0;
      end
    end else begin
      prev_q    <= bus.irq_src;
      // A new edge on the source being acknowledged re-arms it with the fresh payload.
      pending_q <= (pending_q & ~clr_w) | edge_w;
      ovf_q     <= ovf_q | (edge_w & pending_q & ~clr_w);
      for (int j = 0; j < NUM_IRQ; j++) begin
        if (edge_w[j] && (!pending_q[j] || clr_w[j])) begin
          cap_q[j] <= bus.irq_src_data[j*DATA_W +: DATA_W];
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (found_w) begin
            id_q    <= winner_w;
            data_q  <= cap_q[winner_w];
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.irq_ack) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
`ifdef IRQ_ROUND_ROBIN_EN
            last_q  <= id_q;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.irq_req      = req_q;
  assign bus.irq_id       = id_q;
  assign bus.irq_data     = data_q;
  assign bus.irq_overflow = ovf_q;
endmodule

// File: tb/tb_io_dispatch_hub.sv
// tb/tb_io_dispatch_hub.sv - scoreboard bench for io_dispatch_hub with directed and random traffic
module tb_io_dispatch_hub;
  localparam int DATA_W  = 32;
  localparam int NUM_OUT = 3;
  localparam int NUM_IRQ = 2;
  localparam int SEL_W   = 2;
`ifdef IRQ_ROUND_ROBIN_EN
  localparam int FIRST_ID = 1;
`else
  localparam int FIRST_ID = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_dispatch_hub_if #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .NUM_IRQ(NUM_IRQ)) bus ();
  io_dispatch_hub #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .NUM_IRQ(NUM_IRQ)) dut (
    .sys_clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { int id; logic [31:0] data; } grant_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [NUM_OUT][$];
  grant_t      irq_exp [$];

  bit          m_full [NUM_OUT];
  bit          m_pend [NUM_IRQ];
  bit          m_ovf  [NUM_IRQ];
  bit          m_prev [NUM_IRQ];
  logic [31:0] m_data [NUM_IRQ];
  bit          m_req;
  int          m_id, m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM_OUT; i++) begin
      m_full[i] = 1'b0;
      exp_q[i].delete();
    end
    for (int j = 0; j < NUM_IRQ; j++) begin
      m_pend[j] = 1'b0; m_ovf[j] = 1'b0; m_prev[j] = 1'b0; m_data[j] = '0;
    end
    irq_exp.delete();
    m_req = 1'b0; m_id = 0; m_last = 0;
  endtask

  function automatic int pick();
    int start = 0;
`ifdef IRQ_ROUND_ROBIN_EN
    start = m_last + 1;
`endif
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (m_pend[(start + k) % NUM_IRQ]) return (start + k) % NUM_IRQ;
    end
    return -1;
  endfunction

  // One clock of stimulus: check visible state against the model, then advance the model.
  task automatic step(input bit wr, input int sel, input logic [31:0] d, input logic [NUM_OUT-1:0] rdy,
                      input logic [NUM_IRQ-1:0] src, input logic [63:0] sd, input bit ack, input bit r);
    logic [NUM_OUT-1:0] fv;
    logic [NUM_IRQ-1:0] ov;
    bit busy_exp, acc, e, cl, clr, grant;
    int w;
    grant_t g;
    @(negedge clk);
    rst = r; bus.cpu_wr = wr; bus.cpu_sel = SEL_W'(sel); bus.cpu_data = d; bus.out_ready = rdy;
    bus.irq_src = src; bus.irq_src_data = sd; bus.irq_ack = ack;
    #1;
    for (int i = 0; i < NUM_OUT; i++) fv[i] = m_full[i];
    for (int j = 0; j < NUM_IRQ; j++) ov[j] = m_ovf[j];
    busy_exp = 1'b0;
    if (sel < NUM_OUT) busy_exp = m_full[sel] && !rdy[sel];
    chk("out_valid", bus.out_valid, fv);
    chk("cpu_busy", bus.cpu_busy, busy_exp);
    chk("irq_req", bus.irq_req, m_req);
    chk("irq_overflow", bus.irq_overflow, ov);
    if (m_req) chk("irq_id", bus.irq_id, m_id);
    if (r) begin
      reset_model();
      return;
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      acc = wr && sel == i && (!m_full[i] || rdy[i]);
      if (acc) exp_q[i].push_back(d);
      m_full[i] = acc || (m_full[i] && !rdy[i]);
    end
    clr   = m_req && ack;
    w     = pick();
    grant = !m_req && w >= 0;
    if (grant) begin g.id = w; g.data = m_data[w]; end
    for (int j = 0; j < NUM_IRQ; j++) begin
      e  = src[j] && !m_prev[j];
      cl = clr && m_id == j;
      if (e) begin
        if (m_pend[j] && !cl) m_ovf[j] = 1'b1;
        else begin m_pend[j] = 1'b1; m_data[j] = sd[j*32 +: 32]; end
      end else if (cl) begin
        m_pend[j] = 1'b0;
      end
      m_prev[j] = src[j];
    end
    if (grant) begin m_req = 1'b1; m_id = w; irq_exp.push_back(g); end
    if (clr) begin m_req = 1'b0; m_last = m_id; end
  endtask

  initial begin : monitor
    bit req_seen = 1'b0;
    bit have_cur = 1'b0;
    grant_t cur;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (bus.out_valid[i] === 1'b1 && bus.out_ready[i] === 1'b1 && rst === 1'b0) begin
          n_checks++;
          if (exp_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL ch%0d_xfer: got data 0x%0h, expected no transfer", i, bus.out_data[i*32 +: 32]);
          end else begin
            n_checks--;
            chk($sformatf("ch%0d_data", i), bus.out_data[i*32 +: 32], exp_q[i].pop_front());
          end
        end
      end
      if (bus.irq_req === 1'b1) begin
        if (!req_seen) begin
          have_cur = irq_exp.size() != 0;
          if (!have_cur) begin
            n_checks++; n_fail++;
            $display("FAIL irq_grant: got irq_req=1 id %0d, expected no grant", bus.irq_id);
          end else begin
            cur = irq_exp.pop_front();
            chk("grant_id", bus.irq_id, cur.id);
            chk("grant_data", bus.irq_data, cur.data);
          end
        end else if (have_cur) begin
          chk("held_id", bus.irq_id, cur.id);
          chk("held_data", bus.irq_data, cur.data);
        end
      end
      req_seen = (bus.irq_req === 1'b1);
    end
  end

  initial begin : driver
    logic [NUM_IRQ-1:0] src_r;
    bit a;
    rst = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_sel = '0; bus.cpu_data = '0; bus.out_ready = '0;
    bus.irq_src = '0; bus.irq_src_data = '0; bus.irq_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model();
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_irq_req", bus.irq_req, 0);
    chk("rst_irq_id", bus.irq_id, 0);
    chk("rst_irq_data", bus.irq_data, 0);
    chk("rst_irq_overflow", bus.irq_overflow, 0);

    step(1, 1, 32'hDEADBEEF, 3'b000, 2'b00, 64'd0, 0, 0);
    step(0, 0, 32'h0, 3'b000, 2'b00, 64'd0, 0, 0);
    chk("t1_valid", bus.out_valid, 3'b010);
    step(1, 1, 32'h1234, 3'b000, 2'b00, 64'd0, 0, 0);
    chk("t1_busy", bus.cpu_busy, 1);
    step(0, 0, 32'h0, 3'b010, 2'b00, 64'd0, 0, 0);
    chk("t1_kept", bus.out_data[63:32], 32'hDEADBEEF);
    step(1, 3, 32'h9, 3'b000, 2'b00, 64'd0, 0, 0);
    chk("t1_cleared", bus.out_valid, 3'b000);
    chk("sel_oob_busy", bus.cpu_busy, 0);
    step(0, 0, 32'h0, 3'b000, 2'b00, 64'd0, 0, 0);
    chk("sel_oob_ignored", bus.out_valid, 3'b000);

    step(1, 0, 32'h11, 3'b000, 2'b00, 64'd0, 0, 0);
    step(1, 0, 32'h55, 3'b001, 2'b00, 64'd0, 0, 0);
    step(0, 0, 32'h0, 3'b000, 2'b00, 64'd0, 0, 0);
    chk("t2_valid", bus.out_valid[0], 1);
    chk("t2_data", bus.out_data[31:0], 32'h55);
    step(0, 0, 32'h0, 3'b001, 2'b00, 64'd0, 0, 0);

    step(0, 0, 0, 3'b000, 2'b01, {32'd0, 32'd103}, 0, 0);
    step(0, 0, 0, 3'b000, 2'b01, 64'd0, 0, 0);
    chk("t3_no_req_yet", bus.irq_req, 0);
    step(0, 0, 0, 3'b000, 2'b01, 64'd0, 0, 0);
    chk("t3_req", bus.irq_req, 1);
    chk("t3_id", bus.irq_id, 0);
    chk("t3_data", bus.irq_data, 103);
    step(0, 0, 0, 3'b000, 2'b01, 64'd0, 1, 0);
    step(0, 0, 0, 3'b000, 2'b01, 64'd0, 0, 0);
    chk("t3_req_low", bus.irq_req, 0);

    step(0, 0, 0, 3'b000, 2'b00, 64'd0, 0, 0);
    step(0, 0, 0, 3'b000, 2'b11, {32'd200, 32'd100}, 0, 0);
    step(0, 0, 0, 3'b000, 2'b11, 64'd0, 0, 0);
    step(0, 0, 0, 3'b000, 2'b11, 64'd0, 0, 0);
    chk("t4_first_id", bus.irq_id, FIRST_ID);
    chk("t4_first_data", bus.irq_data, FIRST_ID == 0 ? 100 : 200);
    step(0, 0, 0, 3'b000, 2'b11, 64'd0, 1, 0);
    step(0, 0, 0, 3'b000, 2'b11, 64'd0, 0, 0);
    chk("t4_gap", bus.irq_req, 0);
    step(0, 0, 0, 3'b000, 2'b11, 64'd0, 0, 0);
    chk("t4_second_req", bus.irq_req, 1);
    chk("t4_second_id", bus.irq_id, 1 - FIRST_ID);
    step(0, 0, 0, 3'b000, 2'b11, 64'd0, 1, 0);

    step(0, 0, 0, 3'b000, 2'b00, 64'd0, 0, 0);
    step(0, 0, 0, 3'b000, 2'b10, {32'd7, 32'd0}, 0, 0);
    step(0, 0, 0, 3'b000, 2'b00, 64'd0, 0, 0);
    step(0, 0, 0, 3'b000, 2'b10, {32'd9, 32'd0}, 0, 0);
    step(0, 0, 0, 3'b000, 2'b00, 64'd0, 0, 0);
    chk("t5_overflow", bus.irq_overflow, 2'b10);
    chk("t5_data_first", bus.irq_data, 7);
    step(0, 0, 0, 3'b000, 2'b00, 64'd0, 1, 0);
    step(0, 0, 0, 3'b000, 2'b00, 64'd0, 0, 0);
    chk("t5_overflow_kept", bus.irq_overflow, 2'b10);

    step(1, 0, 32'hA0, 3'b000, 2'b01, {32'd0, 32'd5}, 0, 0);
    step(1, 1, 32'hA1, 3'b000, 2'b01, 64'd0, 0, 0);
    step(1, 2, 32'hA2, 3'b000, 2'b01, 64'd0, 0, 0);
    step(0, 0, 0, 3'b000, 2'b01, 64'd0, 0, 0);
    chk("t6_all_full", bus.out_valid, 3'b111);
    chk("t6_req", bus.irq_req, 1);
    step(0, 0, 0, 3'b000, 2'b00, 64'd0, 0, 1);
    step(0, 0, 0, 3'b000, 2'b00, 64'd0, 1, 0);
    chk("t6_valid_zero", bus.out_valid, 0);
    chk("t6_data_zero", bus.out_data, 0);
    chk("t6_req_zero", bus.irq_req, 0);
    chk("t6_irq_data_zero", bus.irq_data, 0);
    chk("t6_ovf_zero", bus.irq_overflow, 0);
    step(0, 0, 0, 3'b000, 2'b00, 64'd0, 0, 0);
    chk("t6_late_ack", bus.irq_req, 0);

    src_r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) src_r = NUM_IRQ'($urandom_range(3));
      a = (bus.irq_req === 1'b1) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      step($urandom_range(1) == 1, $urandom_range(3), $urandom(), 3'($urandom_range(7)),
           src_r, {$urandom(), $urandom()}, a, 0);
    end
    for (int c = 0; c < 30; c++) begin
      a = (bus.irq_req === 1'b1);
      step(0, 0, 0, 3'b111, src_r, 64'd0, a, 0);
    end
    for (int i = 0; i < NUM_OUT; i++) chk($sformatf("ch%0d_drained", i), exp_q[i].size(), 0);
    chk("grants_drained", irq_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
